// File: rtl/mycpu_div_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface mycpu_div_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic                 annul;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 busy;
    logic                 stallreq;

    // Divider side
    modport slave (
        input  start, signed_div, annul, dividend, divisor,
        output result, ready, busy, stallreq
    );

    // EX-stage side
    modport master (
        output start, signed_div, annul, dividend, divisor,
        input  result, ready, busy, stallreq
    );
endinterface

// File: rtl/mycpu_div.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned.
// Result is {remainder, quotient}; a zero divisor short-cuts through DIVZERO.
module mycpu_div #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    mycpu_div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   rem_q;      // partial remainder
    logic [WIDTH-1:0]   quo_q;      // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0]   dsr_q;      // divisor magnitude
    logic               sdiv_q, sgn_a_q, sgn_b_q;
    logic [2*WIDTH-1:0] result_q;

    logic               take;
    logic               last_step;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     shifted, diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;

    assign take      = bus.start & ~bus.annul;
    assign last_step = (cnt_q == CW'(WIDTH-1));

    assign a_neg = bus.signed_div & bus.dividend[WIDTH-1];
    assign b_neg = bus.signed_div & bus.divisor[WIDTH-1];
    assign mag_a = a_neg ? -bus.dividend : bus.dividend;
    assign mag_b = b_neg ? -bus.divisor  : bus.divisor;

    // The shifted remainder is below 2*divisor, so the difference always fits
    // in WIDTH+1 signed bits and its top bit alone tells restore vs keep.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_q};
    assign ge      = ~diff[WIDTH];
    assign rem_nx  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ge};

    // Sign fix-up; most-negative / -1 falls out naturally as quotient = MIN.
    assign quo_fix = (sdiv_q & (sgn_a_q ^ sgn_b_q)) ? -quo_nx : quo_nx;
    assign rem_fix = (sdiv_q & sgn_a_q) ? -rem_nx : rem_nx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: annul always returns to IDLE, start only honoured in IDLE
    always_comb begin
        state_d = state_q;
        if (bus.annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:         if (bus.start) state_d = (bus.divisor == '0) ? DIVZERO : ON;
                ON:           if (last_step) state_d = END;
                DIVZERO, END: state_d = IDLE;
                default:      state_d = IDLE;
            endcase
        end
    end

    // Datapath: operand capture, one restoring step per ON cycle, result write
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            sdiv_q   <= 1'b0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            result_q <= '0;
        end else if (state_q == IDLE && take) begin
            sdiv_q  <= bus.signed_div;
            sgn_a_q <= a_neg;
            sgn_b_q <= b_neg;
            rem_q   <= '0;
            quo_q   <= mag_a;
            dsr_q   <= mag_b;
            cnt_q   <= '0;
            // Result lands on the edge into DIVZERO so it is valid with ready.
            if (bus.divisor == '0) result_q <= {bus.dividend, {WIDTH{1'b1}}};
        end else if (state_q == ON && !bus.annul) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) result_q <= {rem_fix, quo_fix};
        end
    end

    assign bus.result   = result_q;
    assign bus.ready    = ((state_q == END) | (state_q == DIVZERO)) & ~bus.annul;
    assign bus.busy     = (state_q != IDLE);
    // Low in END so the held EX instruction moves on while capturing result.
    assign bus.stallreq = ~bus.annul & (((state_q == IDLE) & bus.start) |
                                        (state_q == ON) | (state_q == DIVZERO));
endmodule

// File: tb/tb_mycpu_div.sv
// Bench for mycpu_div at WIDTH=32 and WIDTH=8: scoreboard queues filled at
// issue time, drained by per-instance monitors whenever ready is seen.
module tb_mycpu_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mycpu_div_if #(.WIDTH(32)) b32();
    mycpu_div_if #(.WIDTH(8))  b8();

    mycpu_div #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    mycpu_div #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] q32[$];
    logic [15:0] q8[$];
    logic [63:0] last32 = '0;
    logic [63:0] e32;
    logic [15:0] e8;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: plain integer division on n-bit operands, C-style truncation.
    function automatic logic [63:0] ref_div(input int n, input logic [31:0] a,
                                            input logic [31:0] b, input bit s);
        longint      sa, sb, q, r;
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        if (b == 0) return ({32'b0, a} << n) | mask;
        if (s) begin
            sa = (longint'(a) << (64 - n)) >>> (64 - n);
            sb = (longint'(b) << (64 - n)) >>> (64 - n);
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return ((64'(r) & mask) << n) | (64'(q) & mask);
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (b32.ready) begin
            if (q32.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rdy32_unexpected: got ready=1 result=%0h expected no ready", b32.result);
            end else begin
                e32 = q32.pop_front();
                chk("result32", b32.result, e32);
                last32 = e32;
            end
        end
    end

    always @(negedge clk) begin
        if (b8.ready) begin
            if (q8.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rdy8_unexpected: got ready=1 result=%0h expected no ready", b8.result);
            end else begin
                e8 = q8.pop_front();
                chk("result8", {48'b0, b8.result}, {48'b0, e8});
            end
        end
    end

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input bit s);
        @(posedge clk); #1;
        b32.start = 1'b1; b32.signed_div = s; b32.dividend = a; b32.divisor = b;
    endtask

    // One division with latency, stall-window and result-hold checks.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s);
        int lat = -1;
        int stl = 0;
        issue32(a, b, s);
        q32.push_back(ref_div(32, a, b, s));
        @(negedge clk);
        if (b32.stallreq) stl++;
        for (int t = 1; t <= 36; t++) begin
            @(posedge clk); #1 b32.start = 1'b0;
            @(negedge clk);
            if (b32.stallreq) stl++;
            if (b32.ready && lat < 0) lat = t;
        end
        chk("lat32",   64'(lat), (b == 0) ? 64'd1 : 64'd33);
        chk("stall32", 64'(stl), (b == 0) ? 64'd2 : 64'd33);
        chk("busy32_idle", {63'b0, b32.busy}, 64'd0);
        chk("hold32", b32.result, last32);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s);
        int lat = -1;
        logic [63:0] r;
        r = ref_div(8, {24'b0, a}, {24'b0, b}, s);
        @(posedge clk); #1;
        b8.start = 1'b1; b8.signed_div = s; b8.dividend = a; b8.divisor = b;
        q8.push_back(r[15:0]);
        for (int t = 1; t <= 12; t++) begin
            @(posedge clk); #1 b8.start = 1'b0;
            @(negedge clk);
            if (b8.ready && lat < 0) lat = t;
        end
        chk("lat8", 64'(lat), (b == 0) ? 64'd1 : 64'd9);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          lat, nrdy, sel;
        b32.start = 0; b32.signed_div = 0; b32.annul = 0; b32.dividend = 0; b32.divisor = 0;
        b8.start  = 0; b8.signed_div  = 0; b8.annul  = 0; b8.dividend  = 0; b8.divisor  = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result32", b32.result, 64'd0);
        chk("rst_flags32", {61'b0, b32.ready, b32.busy, b32.stallreq}, 64'd0);
        chk("rst_result8", {48'b0, b8.result}, 64'd0);
        chk("rst_flags8", {61'b0, b8.ready, b8.busy, b8.stallreq}, 64'd0);
        #1 rst = 1'b0;

        // Directed 32-bit cases
        run32(32'd100, 32'd7, 1'b0);
        run32(32'hFFFF_FFF9, 32'd2, 1'b1);
        run32(32'd7, 32'hFFFF_FFFE, 1'b1);
        run32(32'h1234, 32'd0, 1'b0);
        run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run32(32'h8000_0000, 32'd0, 1'b1);
        run32(32'hFFFF_FFFF, 32'd1, 1'b0);

        // Directed 8-bit cases
        run8(8'h80, 8'hFF, 1'b1);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h81, 8'h07, 1'b1);
        run8(8'h55, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++)
            run8(8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // Annul at T10: no ready, result untouched
        issue32(32'd500, 32'd3, 1'b0);
        @(posedge clk); #1 b32.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 b32.annul = 1'b1;
        @(negedge clk);
        chk("annul_ready", {63'b0, b32.ready}, 64'd0);
        chk("annul_stall", {63'b0, b32.stallreq}, 64'd0);
        @(posedge clk); #1 b32.annul = 1'b0;
        @(negedge clk);
        chk("annul_busy", {63'b0, b32.busy}, 64'd0);
        chk("annul_hold", b32.result, last32);
        repeat (40) @(posedge clk);

        // start together with annul in IDLE
        @(posedge clk); #1 b32.start = 1'b1; b32.annul = 1'b1; b32.divisor = 32'd5;
        @(negedge clk);
        chk("sa_stall", {63'b0, b32.stallreq}, 64'd0);
        @(posedge clk); #1 b32.start = 1'b0; b32.annul = 1'b0;
        @(negedge clk);
        chk("sa_busy", {63'b0, b32.busy}, 64'd0);

        // Reset at T5, restart at T7, spurious start during ON
        issue32(32'd12345, 32'd67, 1'b1);
        @(posedge clk); #1 b32.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_result", b32.result, 64'd0);
        chk("mid_rst_flags", {61'b0, b32.ready, b32.busy, b32.stallreq}, 64'd0);
        last32 = '0;
        #1 rst = 1'b0;
        issue32(32'hDEAD_BEEF, 32'h1234, 1'b0);
        q32.push_back(ref_div(32, 32'hDEAD_BEEF, 32'h1234, 1'b0));
        lat = -1; nrdy = 0;
        for (int t = 1; t <= 45; t++) begin
            @(posedge clk); #1;
            b32.start = (t == 5); b32.dividend = 32'd9; b32.divisor = 32'd4;
            @(negedge clk);
            if (b32.ready) begin
                nrdy++;
                if (lat < 0) lat = t;
            end
        end
        chk("rst_restart_lat", 64'(lat), 64'd33);
        chk("rst_restart_nrdy", 64'(nrdy), 64'd1);

        // Randomised 32-bit traffic with corner-biased divisors
        for (int i = 0; i < 30; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if (sel == 2 && (i % 2 == 0)) ra = 32'h8000_0000;
            run32(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained",  64'(q8.size()),  64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mycpu_div.md
# mycpu_div

Parametrised iterative divider for the EX stage of the five-stage core. It performs one restoring-division step per cycle on operands of `WIDTH` bits, in signed or unsigned mode. It raises a stall request so CTRL freezes IF/ID/EX while a division is in flight. The result is delivered as `{remainder, quotient}`, ready for the HI/LO write path through `ex_to_hilo_bus`.

## Interface
- `WIDTH`, default 32: operand width. Legal values are even and ≥ 4.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division. Sampled only in IDLE.
- `signed_div`  in  1  1 selects two's-complement operands, 0 selects unsigned. Sampled with `start`.
- `annul`  in  1  cancel the operation in progress (EX flush). Takes effect in the same cycle.
- `dividend`  in  WIDTH  dividend. Sampled with `start`.
- `divisor`  in  WIDTH  divisor. Sampled with `start`.
- `result`  out  2*WIDTH  `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`. Registered.
- `ready`  out  1  one-cycle pulse; `result` is valid this cycle.
- `busy`  out  1  state is not IDLE.
- `stallreq`  out  1  combinational stall request to CTRL.

## Operation
- States are IDLE, DIVZERO, ON and END. `rst` forces IDLE with counter = 0, `result` = 0, `ready` = 0 and `busy` = 0.
- **IDLE, on `start` & !`annul`:**
  - Latch `signed_div` and the operand signs.
  - Load the magnitudes: absolute values when signed, raw values when unsigned.
  - If `divisor` == 0, go to DIVZERO. Otherwise go to ON with counter = 0.
- **ON:**
  - Each cycle, shift the partial remainder left by 1 and bring in the next dividend bit, MSB first.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtractor.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Counter increments. After the step with counter == WIDTH-1, go to END.
- **END:**
  - Apply sign fix-up: quotient is negated if the operand signs differ; remainder takes the sign of the dividend; both only in signed mode.
  - Write `result`, assert `ready` for this cycle, and go to IDLE next.
- **DIVZERO:** `result` = `{dividend, {WIDTH{1'b1}}}`, using the raw latched dividend. Assert `ready` and go to IDLE next.
- **Signed overflow** (most-negative / -1): quotient = most-negative value, remainder = 0. The natural magnitude arithmetic with fix-up produces this; no special case is needed.
- **`annul`, any state:** go to IDLE next cycle. `ready` is 0 in the annul cycle. `result` keeps its old value.
- **`annul` and `start` together in IDLE:** `annul` wins and nothing starts.
- **`start` outside IDLE:** ignored.
- **`result` retention:** `result` holds its value after `ready` until the next END or DIVZERO, or until `rst`.
- **`stallreq`** = (IDLE & `start` & !`annul`) | ON | DIVZERO, all qualified by !`annul`. It is 0 in END, so the held EX instruction advances in the same cycle that it captures `result`.

## Timing
- Start cycle is T0, with `start` sampled in IDLE.
- **Normal division:** ON occupies T1..T_WIDTH. END is T_WIDTH+1, where `ready` = 1 and `result` is valid. IDLE is T_WIDTH+2.
  - `stallreq` is high for T0..T_WIDTH, i.e. WIDTH+1 cycles.
  - `busy` is high for T1..T_WIDTH+1.
- **Divide by zero:** DIVZERO is T1 with `ready` = 1. IDLE is T2. `stallreq` is high for T0..T1.
- **Back-to-back divisions:** the earliest new `start` is T_WIDTH+2, giving a minimum initiation interval of WIDTH+2.
- **`rst` mid-operation:** IDLE at the next edge. All outputs take their reset values and no `ready` is produced.

## Test plan
- **Unsigned, WIDTH=32:** 100 / 7 -> `ready` exactly at T33 with `result` = `{32'd2, 32'd14}`. `stallreq` is high for T0..T32 and low at T33.
- **Signed, WIDTH=32:** -7 / 2 -> `result` = `{32'hFFFFFFFF, 32'hFFFFFFFD}`, i.e. rem -1, quot -3. Then 7 / -2 -> `{32'h1, 32'hFFFFFFFD}`.
- **Divide by zero:** 0x1234 / 0 -> `ready` at T1 with `result` = `{32'h1234, 32'hFFFFFFFF}`. `stallreq` is low at T2.
- **WIDTH=8 overflow and unsigned max:** signed 0x80 / 0xFF -> `{8'h00, 8'h80}`. Unsigned 0xFF / 0x01 -> `{8'h00, 8'hFF}`.
- **`annul` at T10:** IDLE at T11, no `ready`, `result` unchanged. `start` together with `annul` in IDLE -> `busy` stays 0.
- **`rst` at T5:** all outputs are 0 at T6. A new `start` at T7 -> correct result at T7+WIDTH+1. `start` pulsed during ON is ignored, i.e. there is no second `ready`.
